// File: rtl/jk_bank_ctrl.sv
// Command-driven sequencer for a bank of JK flip-flop cells.
// Commands queue in a small FIFO; each applies one JK op to masked bits for cmd_rep+1 edges.
module jk_bank_ctrl #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [REP_W-1:0] cmd_rep,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] j_bus,
    output logic [WIDTH-1:0] k_bus,
    output logic             busy,
    output logic             done
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE,
        APPLY
    } state_t;

    state_t state, state_next;

    logic [1:0]       op_mem   [DEPTH];
    logic [WIDTH-1:0] mask_mem [DEPTH];
    logic [REP_W-1:0] rep_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic [1:0]       act_op;
    logic [WIDTH-1:0] act_mask;
    logic [REP_W-1:0] rep_cnt;

    logic push, pop, fifo_empty, last_app;

    // Ready comes only from the registered count, so a full FIFO never takes a push on a pop edge.
    assign cmd_ready  = (count != CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = cmd_valid && cmd_ready;
    assign last_app   = (state == APPLY) && (rep_cnt == '0);
    assign busy       = (state == APPLY) || !fifo_empty;
    assign qb         = ~q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        pop        = 1'b0;
        j_bus      = '0;
        k_bus      = '0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = APPLY;
                end
            end
            APPLY: begin
                j_bus = act_mask & {WIDTH{act_op[1]}};
                k_bus = act_mask & {WIDTH{act_op[0]}};
                if (rep_cnt == '0) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the FIFO storage has no reset; the count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]   <= cmd_op;
            mask_mem[wr_ptr] <= cmd_mask;
            rep_mem[wr_ptr]  <= cmd_rep;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            act_op   <= '0;
            act_mask <= '0;
            rep_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= last_app;
            if (pop) begin
                act_op   <= op_mem[rd_ptr];
                act_mask <= mask_mem[rd_ptr];
                rep_cnt  <= rep_mem[rd_ptr];
            end else if (state == APPLY && rep_cnt != '0) begin
                rep_cnt <= rep_cnt - REP_W'(1);
            end
        end
    end

    // JK characteristic equation; j_bus/k_bus are zero outside APPLY, which reduces to hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= (j_bus & ~q) | (~k_bus & q);
    end

endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Command-driven sequencer for a bank of WIDTH JK flip-flop cells; it owns the bank's J/K drive.
- Requesters push commands over a valid/ready handshake into a small FIFO.
- Each command applies one JK operation (hold/reset/set/toggle) to a masked subset of bits for a programmed number of consecutive clock edges. Toggle with repeat gives counter/divider behaviour.
- Sits between control logic and JK-based register/counter datapaths.

Parameters:
- WIDTH, 8, number of JK cells in the bank.
- REP_W, 4, width of the repeat field; a command is applied cmd_rep+1 times (1..2^REP_W).
- DEPTH, 2, command FIFO depth; power of two, >=2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept (= not full).
- cmd_op  input  2  {j,k} encoding: 00 hold, 01 reset, 10 set, 11 toggle.
- cmd_mask  input  WIDTH  bits to operate on; 0 bits are held.
- cmd_rep  input  REP_W  application count minus one.
- q  output  WIDTH  bank state.
- qb  output  WIDTH  complement of q.
- j_bus  output  WIDTH  J drive currently applied to the cells.
- k_bus  output  WIDTH  K drive currently applied to the cells.
- busy  output  1  state==APPLY or FIFO non-empty.
- done  output  1  one-cycle pulse after a command's final application.

Behaviour:
- Clocking and reset: one clock. rst is asynchronous and active-high and acts immediately, regardless of clock.
- Reset values: q=0, qb=all ones, FIFO empty, cmd_ready=1, state IDLE, rep counter=0, j_bus=k_bus=0, busy=0, done=0.
- Invariant: qb == ~q at all times, including during reset.
- Handshake: a command is accepted on a clock edge where cmd_valid && cmd_ready, and is written to the FIFO tail. cmd_ready is derived from the registered FIFO count. There is no bypass: a full FIFO does not accept a push, even if it pops on the same edge. Inputs are ignored when not accepted.
- FIFO: pointer wrap modulo DEPTH. Simultaneous push and pop when neither full nor empty keeps the count unchanged.
- FSM, IDLE:
  - j_bus=k_bus=0.
  - If the FIFO is non-empty at an edge: pop the head into the active registers (op, mask), load rep counter=cmd_rep, go to APPLY.
  - The entry written on an edge cannot be popped on that same edge.
- FSM, APPLY:
  - j_bus = mask & {WIDTH{op[1]}}; k_bus = mask & {WIDTH{op[0]}} (combinational from the active registers).
  - Each edge updates every cell per JK rules: 00 hold, 01 q<=0, 10 q<=1, 11 q<=~q.
  - If rep counter != 0: decrement, stay in APPLY.
  - If rep counter == 0 (final application): done<=1 for the next cycle. If the FIFO is non-empty, pop the next command in the same edge and stay in APPLY (no idle gap between commands); otherwise go to IDLE.
- Latency: acceptance edge E0, pop at E1, first q update at E2. The last update is at E(2+cmd_rep) for a command reaching an idle controller. done is high during the cycle after the final-update edge.
- Hold op: runs its full repeat count with q unchanged, and still pulses done.
- Mask 0: same as hold.
- Reset mid-operation: the in-flight command and FIFO contents are discarded, with no partial continuation. After release the controller sits in IDLE until a new command arrives.
- No arithmetic overflow: the rep counter only decrements from a loaded value down to 0.

Test Plan:
(WIDTH=8, REP_W=4, DEPTH=2)
1. Reset: assert rst asynchronously -> immediately q=0x00, qb=0xFF, cmd_ready=1, busy=0, done=0, j_bus=k_bus=0.
2. Set: push op=10, mask=0xA5, rep=0 at E0 -> j_bus=0xA5, k_bus=0x00 in the cycle after E1; q=0xA5, qb=0x5A at E2; done high for one cycle after E2; busy low afterwards.
3. Toggle: from q=0xA5 push op=11, mask=0x01, rep=4 -> bit0 toggles on 5 edges, final q=0xA4. Then push op=11, mask=0x0F, rep=15 -> 16 toggles, q returns to 0xA4; busy high throughout.
4. Back-to-back and full FIFO: with the FSM in APPLY on a rep=7 hold, push set 0xFF and reset 0x0F -> cmd_ready drops after 2 queued. Commands execute with no IDLE cycle between them, done pulses once per command, final q=0xF0.
5. Reset during operation: in APPLY of toggle mask=0xFF rep=10, assert rst mid-count -> q=0x00 immediately, FIFO flushed. After release q stays 0x00, busy=0, no done pulse.
6. Hold: from q=0x3C push op=00, mask=0xFF, rep=3 -> q stays 0x3C for 4 edges, busy high 5 cycles from acceptance, single done pulse.
